ps2_key_rx: RTL and testbench

PS/2 keyboard receiver that sits directly upstream of the galaksija core's keyboard matrix logic. It synchronizes and deglitches the raw `ps2clk`/`ps2data` pins (the USB D+/D− pads with pull-ups enabled), deserializes 11-bit device-to-host frames, and checks parity and framing. It folds the E0 (extended) and F0 (break) prefixes into a single one-cycle key event.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_key_rx_filter.sv | 48 ++++
 rtl/ps2_key_rx.sv | 172 +++++++++++++++++
 tb/tb_ps2_key_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// The watchdog (enabled by PS2_RX_TIMEOUT_EN) sizes itself with ps2_timeout_cycles().
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    function automatic int ps2_timeout_cycles(input int clk_freq_hz, input int timeout_us);
        longint cyc;
        cyc = (longint'(clk_freq_hz) * longint'(timeout_us)) / 64'd1000000;
        return int'(cyc);
    endfunction

endpackage

// File: rtl/ps2_key_rx_filter.sv
// PS/2 pin conditioning: 2-FF synchronizers, clock deglitch window and falling-edge strobe.
// fall is high for one cycle, 2 + C_filter_len cycles after a stable raw falling edge.
module ps2_filter #(
    parameter int C_filter_len = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2clk,
    input  logic ps2data,
    output logic fall,
    output logic data_sync
);

    logic [1:0]              clk_sync_q, clk_sync_d;
    logic [1:0]              dat_sync_q, dat_sync_d;
    logic [C_filter_len-1:0] hist_q, hist_d;
    logic                    filt_q, filt_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2clk};
        dat_sync_d = {dat_sync_q[0], ps2data};
        hist_d     = {hist_q[C_filter_len-2:0], clk_sync_q[1]};
        filt_d     = filt_q;
        if (&hist_q)
            filt_d = 1'b1;
        else if (~|hist_q)
            filt_d = 1'b0;
    end

    // Lines idle high through the pull-ups, so reset everything to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            hist_q     <= '1;
            filt_q     <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            hist_q     <= hist_d;
            filt_q     <= filt_d;
        end
    end

    assign fall      = filt_q & ~|hist_q;
    assign data_sync = dat_sync_q[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frame FSM, E0/F0 prefix folding and optional inter-edge watchdog.
// Define PS2_RX_TIMEOUT_EN to abort stalled frames after C_timeout_us.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int C_clk_freq_hz = 25000000,
    parameter int C_filter_len  = 8,
    parameter int C_timeout_us  = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_released,
    output logic       key_extended,
    output logic       frame_err
);

    localparam int TO_CYC = ps2_timeout_cycles(C_clk_freq_hz, C_timeout_us);

    if (C_filter_len < 2 || C_filter_len > 16) begin : g_bad_filter
        $error("ps2_key_rx: C_filter_len out of range");
    end
    if (TO_CYC < 2) begin : g_bad_timeout
        $error("ps2_key_rx: timeout too short");
    end

    logic fall, data_sync;

    ps2_filter #(.C_filter_len(C_filter_len)) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .fall      (fall),
        .data_sync (data_sync)
    );

    ps2_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       par_q, par_d;
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic [7:0] code_q, code_d;
    logic       kext_q, kext_d;
    logic       krel_q, krel_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        par_d   = par_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        code_d  = code_q;
        kext_d  = kext_q;
        krel_d  = krel_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_sync) begin
                        state_d = ST_DATA;
                        cnt_d   = 3'd0;
                    end
                end
                ST_DATA: begin
                    byte_d = {data_sync, byte_q[7:1]};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7)
                        state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = data_sync;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_sync && (^{byte_q, par_q})) begin
                        if (byte_q == PS2_EXT)
                            ext_d = 1'b1;
                        else if (byte_q == PS2_BRK)
                            rel_d = 1'b1;
                        else begin
                            code_d  = byte_q;
                            kext_d  = ext_q;
                            krel_d  = rel_q;
                            valid_d = 1'b1;
                            ext_d   = 1'b0;
                            rel_d   = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef PS2_RX_TIMEOUT_EN
        // Down-counter reloads on every edge; expiry only possible when no fall this cycle.
        to_d = to_q;
        if (state_q == ST_IDLE || fall)
            to_d = TO_W'(TO_CYC - 1);
        else if (to_q == '0) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end else
            to_d = to_q - 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            par_q   <= 1'b0;
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            code_q  <= '0;
            kext_q  <= 1'b0;
            krel_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            par_q   <= par_d;
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            code_q  <= code_d;
            kext_q  <= kext_d;
            krel_q  <= krel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            to_q <= TO_W'(TO_CYC - 1);
        else
            to_q <= to_d;
    end
`endif

    assign key_valid    = valid_q;
    assign key_code     = code_q;
    assign key_released = krel_q;
    assign key_extended = kext_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: directed frames push expected events, a monitor pops and compares.
module tb_ps2_key_rx;

    localparam int L    = 8;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_released;
    logic       key_extended;
    logic       frame_err;

    ps2_key_rx #(
        .C_clk_freq_hz (25000000),
        .C_filter_len  (L),
        .C_timeout_us  (200)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2clk       (ps2clk),
        .ps2data      (ps2data),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_released (key_released),
        .key_extended (key_extended),
        .frame_err    (frame_err)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        logic       rel;
        logic       ext;
        logic       err;
        logic       chk_lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_edge = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && (key_valid || frame_err)) begin
            check("strobes_exclusive", int'(key_valid && frame_err), 0);
            if (exp_q.size() == 0)
                check("unexpected_event", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("event_is_err", int'(frame_err), int'(mon_e.err));
                if (!mon_e.err) begin
                    check("key_code", int'(key_code), int'(mon_e.code));
                    check("key_released", int'(key_released), int'(mon_e.rel));
                    check("key_extended", int'(key_extended), int'(mon_e.ext));
                end
                if (mon_e.chk_lat)
                    check("latency", cyc - last_edge, 3 + L);
            end
        end
    end

    task automatic expect_key(input logic [7:0] code, input logic rel, input logic ext);
        exp_t e;
        e.code = code; e.rel = rel; e.ext = ext; e.err = 1'b0; e.chk_lat = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic chk_lat);
        exp_t e;
        e.code = 8'h00; e.rel = 1'b0; e.ext = 1'b0; e.err = 1'b1; e.chk_lat = chk_lat;
        exp_q.push_back(e);
    endtask

    // Frame bits: start, 8 data LSB first, odd parity (optionally corrupted), stop.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_after);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2data = f[i];
            if (glitch_after == i) begin
                repeat (HALF / 2) @(negedge clk);
                ps2clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2clk = 1'b1;
                repeat (HALF / 2 - 3) @(negedge clk);
            end else
                repeat (HALF) @(negedge clk);
            ps2clk    = 1'b0;
            last_edge = cyc;
            repeat (HALF) @(negedge clk);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_key_valid"}, int'(key_valid), 0);
        check({tag, "_key_code"}, int'(key_code), 0);
        check({tag, "_key_released"}, int'(key_released), 0);
        check({tag, "_key_extended"}, int'(key_extended), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, -1);

        send_frame(8'hF0, 1'b0, 11, -1);
        expect_key(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 11, -1);

        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'hF0, 1'b0, 11, -1);
        expect_key(8'h75, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 11, -1);
        expect_key(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 11, -1);

        expect_err(1'b1);
        send_frame(8'h1C, 1'b1, 11, -1);
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, -1);

        // A parity error must also drop a pending break prefix.
        send_frame(8'hF0, 1'b0, 11, -1);
        expect_err(1'b1);
        send_frame(8'h1C, 1'b1, 11, -1);
        expect_key(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 11, -1);

        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 4);

        // Pending E0 and a partial frame, then reset: both must be forgotten.
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b0, 5, -1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, -1);

`ifdef PS2_RX_TIMEOUT_EN
        expect_err(1'b0);
        send_frame(8'h1C, 1'b0, 5, -1);
        repeat (5100) @(negedge clk);
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, -1);
`endif

        repeat (50) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
